multi_bit_sync_filt: RTL and testbench

Parametrised successor to the team's flop-chain synchroniser. Each of CH_NUM asynchronous single-bit inputs passes through a NUM_STAGES flop chain into the clk domain. A per-channel stability (glitch) filter follows the chain, then per-channel rise/fall pulse generation. A hold control freezes the filtered outputs. Used for asynchronous control/status bits (IRQ lines, straps, handshake flags) entering a block's clock domain.

---
 rtl/sync_pkg.sv | 19 +
 rtl/sync_filt_ch.sv | 94 +++++++++
 rtl/multi_bit_sync_filt.sv | 73 +++++++
 tb/tb_multi_bit_sync_filt.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the multi-bit synchroniser/filter: stage-depth floor,
// filter counter sizing and the per-channel debug state encoding.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  typedef enum logic {
    CH_STABLE  = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_e;

  // A depth of 1 would give a zero-width counter, so the width never drops below 1.
  function automatic int cnt_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: NUM_STAGES flop synchroniser, stability filter and edge pulses.
// Pulse registers exist only when SYNC_EDGE_DET_EN is defined; otherwise they are tied 0.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   NUM_STAGES = 2,
  parameter int   FILT_DEPTH = 3,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pls,
  output logic fall_pls
`ifdef SYNC_EDGE_DET_EN
  ,
  output logic chg_nxt
`endif
);

  localparam int             CW      = cnt_width(FILT_DEPTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_DEPTH - 1);

  logic [NUM_STAGES-1:0] chain_q, chain_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sync_q, sync_d;
  logic                  sync_raw;
  logic                  accept;
  ch_state_e             ch_state;

  assign sync_raw = chain_q[NUM_STAGES-1];
  assign ch_state = (cnt_q == '0) ? CH_STABLE : CH_PENDING;
  // A differing value is taken once it has already been seen FILT_DEPTH-1 times.
  assign accept   = !hold && (sync_raw != sync_q) && (cnt_q == CNT_MAX);

  // NOTE: every output of a combinational block is given a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    chain_d = {chain_q[NUM_STAGES-2:0], async_in};
    cnt_d   = '0;
    sync_d  = sync_q;
    if (accept) begin
      sync_d = sync_raw;
    end else if (!hold && (sync_raw != sync_q)) begin
      cnt_d = (ch_state == CH_STABLE) ? CW'(1) : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_q <= {NUM_STAGES{RST_VAL}};
      cnt_q   <= '0;
      sync_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
    end
  end

  assign sync_out = sync_q;

`ifdef SYNC_EDGE_DET_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = accept &  sync_raw;
    fall_d = accept & ~sync_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pls = rise_q;
  assign fall_pls = fall_q;
  assign chg_nxt  = rise_d | fall_d;
`else
  assign rise_pls = 1'b0;
  assign fall_pls = 1'b0;
`endif

endmodule

// File: rtl/multi_bit_sync_filt.sv
// CH_NUM independent synchronise-and-filter channels plus a combined change flag.
// Edge pulses and chg_any are built only when SYNC_EDGE_DET_EN is defined.
module multi_bit_sync_filt
  import sync_pkg::*;
#(
  parameter int                CH_NUM     = 4,
  parameter int                NUM_STAGES = 2,
  parameter int                FILT_DEPTH = 3,
  parameter logic [CH_NUM-1:0] RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [CH_NUM-1:0] async_in,
  output logic [CH_NUM-1:0] sync_out,
  output logic [CH_NUM-1:0] rise_pls,
  output logic [CH_NUM-1:0] fall_pls,
  output logic              chg_any
);

  if (NUM_STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("multi_bit_sync_filt: NUM_STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILT_DEPTH < 1) begin : g_bad_depth
    $error("multi_bit_sync_filt: FILT_DEPTH must be >= 1");
  end

`ifdef SYNC_EDGE_DET_EN
  logic [CH_NUM-1:0] chg_nxt;
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    sync_filt_ch #(
      .NUM_STAGES (NUM_STAGES),
      .FILT_DEPTH (FILT_DEPTH),
      .RST_VAL    (RST_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .async_in (async_in[i]),
      .sync_out (sync_out[i]),
      .rise_pls (rise_pls[i]),
      .fall_pls (fall_pls[i])
`ifdef SYNC_EDGE_DET_EN
      ,
      .chg_nxt  (chg_nxt[i])
`endif
    );
  end

`ifdef SYNC_EDGE_DET_EN
  logic chg_any_q, chg_any_d;

  // Registered from the channels' next-state pulses so it lines up with them.
  always_comb begin
    chg_any_d = |chg_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      chg_any_q <= 1'b0;
    end else begin
      chg_any_q <= chg_any_d;
    end
  end

  assign chg_any = chg_any_q;
`else
  assign chg_any = 1'b0;
`endif

endmodule

// File: tb/tb_multi_bit_sync_filt.sv
// Directed bench for multi_bit_sync_filt (CH_NUM=4, NUM_STAGES=2, FILT_DEPTH=3).
// Pulse expectations follow SYNC_EDGE_DET_EN: zero when the macro is undefined.
module tb_multi_bit_sync_filt;

`ifdef SYNC_EDGE_DET_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic [3:0] async_in;
  logic [3:0] sync_out, rise_pls, fall_pls;
  logic       chg_any;
  logic [12:0] obs;
  logic [12:0] exp_v;

  int checks   = 0;
  int failures = 0;

  multi_bit_sync_filt #(
    .CH_NUM     (4),
    .NUM_STAGES (2),
    .FILT_DEPTH (3),
    .RST_VAL    (4'b0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .async_in (async_in),
    .sync_out (sync_out),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls),
    .chg_any  (chg_any)
  );

  always #5 clk = ~clk;

  assign obs = {sync_out, rise_pls, fall_pls, chg_any};

  // Packs an expected {sync_out, rise, fall, chg_any} observation.
  function automatic logic [12:0] ex(input logic [3:0] o, input logic [3:0] r,
                                     input logic [3:0] f);
    ex = {o, PE ? r : 4'h0, PE ? f : 4'h0, PE && ((r | f) != 4'h0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    hold     = 1'b0;
    async_in = 4'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    hold     = 1'b0;
    async_in = 4'hF;
    for (int e = 1; e <= 2; e++) begin
      tick();
      exp_v = ex(4'h0, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_hold e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e < 5)  ? ex(4'h0, 4'h0, 4'h0) :
              (e == 5) ? ex(4'hF, 4'hF, 4'h0) : ex(4'hF, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_release e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    async_in = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e < 5)  ? ex(4'h0, 4'h0, 4'h0) :
              (e == 5) ? ex(4'h1, 4'h1, 4'h0) : ex(4'h1, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL step_rise e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    async_in = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e < 5)  ? ex(4'h1, 4'h0, 4'h0) :
              (e == 5) ? ex(4'h0, 4'h0, 4'h1) : ex(4'h0, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL step_fall e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    async_in = 4'h2;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 2) async_in = 4'h0;
      exp_v = ex(4'h0, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL glitch_short e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    async_in = 4'h2;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) async_in = 4'h0;
      case (e)
        5:       exp_v = ex(4'h2, 4'h2, 4'h0);
        6, 7:    exp_v = ex(4'h2, 4'h0, 4'h0);
        8:       exp_v = ex(4'h0, 4'h0, 4'h2);
        default: exp_v = ex(4'h0, 4'h0, 4'h0);
      endcase
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL glitch_min e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold     = 1'b1;
    async_in = 4'h4;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_v = ex(4'h0, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL hold_frozen e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    hold = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp_v = (e < 3)  ? ex(4'h0, 4'h0, 4'h0) :
              (e == 3) ? ex(4'h4, 4'h4, 4'h0) : ex(4'h4, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL hold_release e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    async_in = 4'h8;
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) rst = 1'b0;
      tick();
      exp_v = ex(4'h0, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e < 5)  ? ex(4'h0, 4'h0, 4'h0) :
              (e == 5) ? ex(4'h8, 4'h8, 4'h0) : ex(4'h8, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_release e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    async_in = 4'h5;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_v = (e < 5) ? ex(4'h0, 4'h0, 4'h0) : ex(4'h5, 4'h5, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL multi_rise e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    async_in = 4'hA;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e < 5)  ? ex(4'h5, 4'h0, 4'h0) :
              (e == 5) ? ex(4'hA, 4'hA, 4'h5) : ex(4'hA, 4'h0, 4'h0);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL multi_swap e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    hold     = 1'b0;
    async_in = 4'h0;
    test_reset();
    test_step();
    test_glitch();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
